lbp: RTL and testbench
======================

Name: lbp

Overview:
- Computes the 8-bit Local Binary Pattern (LBP) of a 128x128 8-bit grayscale image.
- Reads pixels from an external gray-image memory through a request/address port.
- Writes one LBP code per interior pixel to an external result memory, then raises finish.
- Sits between the image source memory and the LBP result memory in the image-processing datapath.

Parameters:
- IMG_W, 128, image width in pixels (power of two; column index uses 7 bits)
- IMG_H, 128, image height in pixels (row index uses 7 bits)

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- gray_ready  input  1  source memory ready; no request may be issued before it is first seen high
- gray_req  output  1  read request to source memory
- gray_addr  output  14  pixel address = row*128 + col ({row[6:0], col[6:0]})
- gray_data  input  8  pixel value returned for gray_addr
- lbp_valid  output  1  write strobe to result memory
- lbp_addr  output  14  result address = row*128 + col of the center pixel
- lbp_data  output  8  LBP code for that center
- finish  output  1  all results written; stays high until reset

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, FSM to IDLE, center position to (row 1, col 1). A reset mid-run aborts the run; the full scan restarts after reset is released.
- Read timing:
  - gray_req and gray_addr are registered and change only after a rising edge.
  - The memory drives gray_data during the low phase of that same cycle.
  - The DUT captures gray_data at the next rising edge: 1-cycle read latency.
  - gray_data is undefined (Z) whenever gray_req is 0 and must never be captured then.
- Write timing:
  - lbp_valid, lbp_addr and lbp_data are registered and held stable for one full cycle.
  - The sink samples them on the falling edge.
  - lbp_valid is high for exactly one cycle per result.
- Scan order: raster, centers row 1..126, col 1..126 (15876 centers). Border pixels (row or col 0 or 127) are never written; the sink is pre-zeroed, so border results read 0.
- Neighbour indexing: g0 (r-1,c-1), g1 (r-1,c), g2 (r-1,c+1), g3 (r,c-1), g4 (r,c+1), g5 (r+1,c-1), g6 (r+1,c), g7 (r+1,c+1); center gc at (r,c).
- LBP code: bit p = 1 if gp >= gc (unsigned 8-bit compare, equality counts as 1), else 0. Bit 0 is the LSB.
- FSM:
  - IDLE: wait for gray_ready=1.
  - READ: issue 9 consecutive requests (center first, then g0..g7), one per cycle, gray_req high throughout. Capture each datum one cycle after its request.
  - WRITE: one cycle with lbp_valid=1, gray_req=0. Then advance col; at col 126 wrap to col 1 and row+1.
  - After center (126,126) is written (lbp_addr 16254), go to DONE.
  - DONE: finish=1, gray_req=0, lbp_valid=0, held until reset.
- gray_ready dropping mid-run is not supported; gray_ready is only checked in IDLE.
- Throughput: at most 11 cycles per center; full image done in under 180k cycles. Window reuse (reading 3 new pixels per step) is permitted if the port timing above is preserved.
- No combinational path from any input to any output.

Test Plan:
- Reset held low, gray_ready=0 -> all outputs 0. Release reset, keep gray_ready=0 for 50 cycles -> gray_req stays 0.
- Constant image (all pixels 0x5A) -> every interior result 0xFF, border results 0, finish rises once after address 16254 is written.
- Pixel value = column index -> every interior result 0xD6 (bits 1,2,4,6,7 set).
- All-zero image with pixel (5,5)=100 -> result(5,5)=0x00, all other interior results 0xFF.
- Random image checked against a software LBP model -> zero mismatches over all 16384 addresses; lbp_valid pulse count = 15876; no writes to border addresses.
- Assert reset mid-scan (around center (40,70)), release -> outputs clear immediately, scan restarts at (1,1), final memory contents correct, finish asserted once.

Source files
------------

// File: rtl/lbp_if.sv
// Bus bundle between the LBP engine, the gray-image source memory and the
// LBP result memory.
//   gray_ready  source memory ready (memory -> engine)
//   gray_req    read request, registered (engine -> memory)
//   gray_addr   pixel address {row[6:0], col[6:0]} (engine -> memory)
//   gray_data   pixel returned for gray_addr, 1-cycle latency (memory -> engine)
//   lbp_valid   one-cycle write strobe (engine -> sink)
//   lbp_addr    result address {row[6:0], col[6:0]} of the center (engine -> sink)
//   lbp_data    LBP code for that center (engine -> sink)
//   finish      all results written, held until reset (engine -> sink)
interface lbp_if;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;

  modport master (
    input  gray_ready, gray_data,
    output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );

  modport slave (
    output gray_ready, gray_data,
    input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish
  );
endinterface

// File: rtl/lbp.sv
// Local Binary Pattern engine. Scans the interior centers of an
// IMG_W x IMG_H 8-bit image in raster order, reads the center and its eight
// neighbours from the source memory (one request per cycle, 1-cycle read
// latency) and writes one 8-bit LBP code per center, then raises finish.
// Ports:
//   clk    system clock, rising-edge active
//   reset  asynchronous, active-low reset
//   bus    lbp_if master modport (gray read port, lbp write port, finish)
// All outputs are registered; no combinational input-to-output path.
module lbp #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128
) (
  input  logic  clk,
  input  logic  reset,
  lbp_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [6:0] LAST_ROW = 7'(IMG_H - 2);
  localparam logic [6:0] LAST_COL = 7'(IMG_W - 2);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;      // index of the request currently on the bus
  logic [6:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [7:0]  gc_q, gc_d;
  logic [6:0]  code_q, code_d;    // bits 0..6; bit 7 goes straight to lbp_data
  logic        req_q, req_d;
  logic [13:0] gaddr_q, gaddr_d;
  logic        valid_q, valid_d;
  logic [13:0] laddr_q, laddr_d;
  logic [7:0]  ldata_q, ldata_d;
  logic        fin_q, fin_d;
  logic        gbit;

  // Request k=0 is the center, k=1..8 are g0..g7.
  function automatic logic [13:0] nb_addr(input logic [6:0] r,
                                          input logic [6:0] c,
                                          input logic [3:0] k);
    logic [6:0] rr;
    logic [6:0] cc;
    rr = r;
    cc = c;
    case (k)
      4'd1: begin rr = r - 7'd1; cc = c - 7'd1; end
      4'd2: begin rr = r - 7'd1;                end
      4'd3: begin rr = r - 7'd1; cc = c + 7'd1; end
      4'd4: begin                cc = c - 7'd1; end
      4'd5: begin                cc = c + 7'd1; end
      4'd6: begin rr = r + 7'd1; cc = c - 7'd1; end
      4'd7: begin rr = r + 7'd1;                end
      4'd8: begin rr = r + 7'd1; cc = c + 7'd1; end
      default: ;
    endcase
    return {rr, cc};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= 7'd1;
      col_q   <= 7'd1;
      gc_q    <= '0;
      code_q  <= '0;
      req_q   <= 1'b0;
      gaddr_q <= '0;
      valid_q <= 1'b0;
      laddr_q <= '0;
      ldata_q <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      gc_q    <= gc_d;
      code_q  <= code_d;
      req_q   <= req_d;
      gaddr_q <= gaddr_d;
      valid_q <= valid_d;
      laddr_q <= laddr_d;
      ldata_q <= ldata_d;
      fin_q   <= fin_d;
    end
  end

  // gray_data is only meaningful while req_q is high, which holds in every
  // READ cycle; gbit is only consumed there.
  assign gbit = (bus.gray_data >= gc_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    gc_d    = gc_q;
    code_d  = code_q;
    req_d   = 1'b0;
    gaddr_d = gaddr_q;
    valid_d = 1'b0;
    laddr_d = laddr_q;
    ldata_d = ldata_q;
    fin_d   = fin_q;

    case (state_q)
      IDLE: begin
        if (bus.gray_ready) begin
          state_d = READ;
          idx_d   = '0;
          req_d   = 1'b1;
          gaddr_d = nb_addr(row_q, col_q, 4'd0);
        end
      end

      READ: begin
        if (idx_q == 4'd0) begin
          gc_d   = bus.gray_data;
          code_d = '0;
        end else begin
          for (int unsigned i = 0; i < 7; i++) begin
            if (idx_q == 4'(i + 1)) code_d[i] = gbit;
          end
        end
        if (idx_q != 4'd8) begin
          idx_d   = 4'(idx_q + 4'd1);
          req_d   = 1'b1;
          gaddr_d = nb_addr(row_q, col_q, 4'(idx_q + 4'd1));
        end else begin
          // Last neighbour arrives now; its compare bit is folded straight
          // into the write so the result leaves one cycle after capture.
          state_d = WRITE;
          valid_d = 1'b1;
          laddr_d = {row_q, col_q};
          ldata_d = {gbit, code_q};
        end
      end

      WRITE: begin
        if (row_q == LAST_ROW && col_q == LAST_COL) begin
          state_d = DONE;
          fin_d   = 1'b1;
        end else begin
          if (col_q == LAST_COL) begin
            col_d = 7'd1;
            row_d = row_q + 7'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
          state_d = READ;
          idx_d   = '0;
          req_d   = 1'b1;
          gaddr_d = nb_addr(row_d, col_d, 4'd0);
        end
      end

      DONE: ;

      default: state_d = IDLE;
    endcase
  end

  assign bus.gray_req  = req_q;
  assign bus.gray_addr = gaddr_q;
  assign bus.lbp_valid = valid_q;
  assign bus.lbp_addr  = laddr_q;
  assign bus.lbp_data  = ldata_q;
  assign bus.finish    = fin_q;

endmodule

// File: tb/tb_lbp.sv
// Self-checking bench for lbp. Runs a reduced 16x16 image (via parameter
// overrides) through constant, column-ramp, single-spike and random images,
// plus a random run with a mid-scan reset, and compares the written result
// memory against a plain-arithmetic LBP model.
module tb_lbp;

  localparam int unsigned W = 16;
  localparam int unsigned H = 16;
  localparam int unsigned N_CENTERS = (W - 2) * (H - 2);
  localparam int unsigned LAST_ADDR = (H - 2) * 128 + (W - 2);

  logic clk = 1'b0;
  logic reset = 1'b0;
  lbp_if bus ();

  lbp #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] img [0:16383];
  logic [7:0] res [0:16383];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned wr_count, border_wr, long_pulse, req_during_wr, fin_rises;
  logic [13:0] first_addr, last_addr, fin_addr;
  logic        valid_prev, fin_prev;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source memory: answers during the low phase of the request cycle.
  always @(negedge clk) begin
    if (bus.gray_req) bus.gray_data = img[bus.gray_addr];
    else              bus.gray_data = 8'bz;
  end

  // Result sink plus protocol monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.lbp_valid) begin
      res[bus.lbp_addr] = bus.lbp_data;
      if (wr_count == 0) first_addr = bus.lbp_addr;
      last_addr = bus.lbp_addr;
      wr_count++;
      if (bus.lbp_addr[13:7] == 7'd0 || int'(bus.lbp_addr[13:7]) >= H - 1 ||
          bus.lbp_addr[6:0] == 7'd0 || int'(bus.lbp_addr[6:0]) >= W - 1)
        border_wr++;
      if (valid_prev) long_pulse++;
      if (bus.gray_req) req_during_wr++;
    end
    if (bus.finish && !fin_prev) begin
      fin_rises++;
      fin_addr = last_addr;
    end
    valid_prev = bus.lbp_valid;
    fin_prev   = bus.finish;
  end

  task automatic clear_stats();
    wr_count = 0; border_wr = 0; long_pulse = 0; req_during_wr = 0; fin_rises = 0;
    first_addr = '0; last_addr = '0; fin_addr = '0;
    valid_prev = 1'b0; fin_prev = 1'b0;
  endtask

  // Reference LBP straight from the definition: neighbour p sets bit p when
  // it is >= the center; outside the interior the sink stays zero.
  function automatic logic [7:0] ref_lbp(input int r, input int c);
    int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0] code;
    logic [7:0] gc;
    if (r < 1 || r > int'(H) - 2 || c < 1 || c > int'(W) - 2) return 8'h00;
    gc   = img[r * 128 + c];
    code = 8'h00;
    for (int p = 0; p < 8; p++)
      if (img[(r + dr[p]) * 128 + (c + dc[p])] >= gc) code[p] = 1'b1;
    return code;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req"},    bus.gray_req,  0);
    check({tag, "_gaddr"},  bus.gray_addr, 0);
    check({tag, "_valid"},  bus.lbp_valid, 0);
    check({tag, "_laddr"},  bus.lbp_addr,  0);
    check({tag, "_ldata"},  bus.lbp_data,  0);
    check({tag, "_finish"}, bus.finish,    0);
  endtask

  // kind: 0 constant 0x5A, 1 pixel = column, 2 zero with spike at (5,5), 3 random
  task automatic run_image(input int kind, input bit mid_reset);
    bit done;
    for (int i = 0; i < 16384; i++) begin
      case (kind)
        0:       img[i] = 8'h5A;
        1:       img[i] = 8'(i % 128);
        2:       img[i] = (i == 5 * 128 + 5) ? 8'd100 : 8'd0;
        default: img[i] = 8'($urandom_range(0, 255));
      endcase
      res[i] = 8'h00;
    end

    @(negedge clk);
    reset = 1'b0;
    bus.gray_ready = 1'b0;
    #1 clear_stats();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.gray_ready = 1'b1;

    if (mid_reset) begin
      done = 0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (wr_count >= 90) begin done = 1; break; end
      end
      check("midrun_reach", done, 1);
      #3 reset = 1'b0;
      #1 check_outputs_zero("midrun_reset");
      clear_stats();
      @(negedge clk);
      reset = 1'b1;
    end

    done = 0;
    for (int i = 0; i < int'(N_CENTERS) * 11 + 200; i++) begin
      @(negedge clk);
      if (bus.finish) begin done = 1; break; end
    end
    check("finish_timeout", done, 1);
    repeat (20) @(negedge clk);

    check("finish_held",   bus.finish,    1);
    check("done_req",      bus.gray_req,  0);
    check("done_valid",    bus.lbp_valid, 0);
    check("write_count",   wr_count,      N_CENTERS);
    check("border_writes", border_wr,     0);
    check("long_pulse",    long_pulse,    0);
    check("req_in_write",  req_during_wr, 0);
    check("finish_rises",  fin_rises,     1);
    check("finish_addr",   fin_addr,      LAST_ADDR);
    check("first_addr",    first_addr,    129);

    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 128; c++)
        check($sformatf("res_k%0d_r%0d_c%0d", kind, r, c), res[r * 128 + c], ref_lbp(r, c));

    case (kind)
      0: begin
        check("const_interior", res[3 * 128 + 4], 8'hFF);
        check("const_border",   res[0 * 128 + 4], 8'h00);
      end
      1: check("column_ramp",   res[2 * 128 + 7], 8'hD6);
      2: begin
        check("spike_center",   res[5 * 128 + 5], 8'h00);
        check("spike_diag",     res[4 * 128 + 4], 8'hFF);
        check("spike_below",    res[6 * 128 + 5], 8'hFF);
      end
      default: ;
    endcase
  endtask

  initial begin
    bus.gray_ready = 1'b0;
    bus.gray_data  = 8'bz;
    clear_stats();

    #12 check_outputs_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("req_before_ready", bus.gray_req, 0);
    end

    run_image(0, 1'b0);
    run_image(1, 1'b0);
    run_image(2, 1'b0);
    run_image(3, 1'b0);
    run_image(3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
